// File: rtl/bp_me_burst_to_lite_pkg.sv
// Shared BedRock definitions for the burst-to-lite converter.
// Provides the message type/size enums, the packed header struct, and
// the helper that derives the number of burst data beats from a message size.
package bp_me_burst_to_lite_pkg;

   localparam int unsigned paddr_width_gp   = 40;
   localparam int unsigned payload_width_gp = 16;
   localparam int unsigned msg_type_width_gp = 4;

   typedef enum logic [3:0] {
      e_bedrock_mem_rd    = 4'd0,
      e_bedrock_mem_wr    = 4'd1,
      e_bedrock_mem_uc_rd = 4'd2,
      e_bedrock_mem_uc_wr = 4'd3,
      e_bedrock_mem_pre   = 4'd4,
      e_bedrock_mem_amo   = 4'd5
   } bedrock_msg_type_e;

   typedef enum logic [2:0] {
      e_bedrock_msg_size_1   = 3'd0,
      e_bedrock_msg_size_2   = 3'd1,
      e_bedrock_msg_size_4   = 3'd2,
      e_bedrock_msg_size_8   = 3'd3,
      e_bedrock_msg_size_16  = 3'd4,
      e_bedrock_msg_size_32  = 3'd5,
      e_bedrock_msg_size_64  = 3'd6,
      e_bedrock_msg_size_128 = 3'd7
   } bedrock_msg_size_e;

   typedef struct packed {
      logic [payload_width_gp-1:0] payload;
      bedrock_msg_size_e           size;
      logic [paddr_width_gp-1:0]   addr;
      bedrock_msg_type_e           msg_type;
   } bedrock_header_s;

   localparam int unsigned header_width_gp = $bits(bedrock_header_s);

   // Beats needed for a message: at least one, never more than the Lite word holds
   function automatic int unsigned burst_beats(input logic [2:0] size,
                                               input int unsigned beat_bytes,
                                               input int unsigned max_beats);
      int unsigned beats;
      beats = (32'd1 << size) / beat_bytes;
      if (beats == 0) beats = 1;
      if (beats > max_beats) beats = max_beats;
      return beats;
   endfunction

endpackage

// File: rtl/bp_me_burst_sipo_dynamic.sv
// Serial-in parallel-out beat collector with a per-message length.
// Ports: load_i/len_i start a message of len_i beats; v_i/data_i write the
// next beat; last_c_o flags that the current write slot is the final beat;
// full_o is set once len_i beats are held; data_o is the collected beats
// with the first len beats replicated across the whole output width.
module bp_me_burst_sipo_dynamic #(
   parameter int unsigned width_p = 64,
   parameter int unsigned els_p   = 8,
   localparam int unsigned len_width_lp = $clog2(els_p + 1),
   localparam int unsigned idx_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic                        load_i,
   input  logic [len_width_lp-1:0]     len_i,
   input  logic                        v_i,
   input  logic [width_p-1:0]          data_i,
   output logic                        last_c_o,
   output logic                        full_o,
   output logic [els_p*width_p-1:0]    data_o
);

   logic [els_p-1:0][width_p-1:0] mem_q, mem_d;
   logic [len_width_lp-1:0]       idx_q, idx_d;
   logic [len_width_lp-1:0]       len_q, len_d;
   logic [idx_width_lp-1:0]       len_mask;

   assign full_o   = (idx_q == len_q);
   assign last_c_o = (idx_q == len_q - len_width_lp'(1));

   // Beat write and index advance; a load restarts the message
   always_comb begin
      mem_d = mem_q;
      idx_d = idx_q;
      len_d = len_q;
      if (load_i) begin
         idx_d = '0;
         len_d = len_i;
      end else if (v_i && !full_o) begin
         mem_d[idx_q[idx_width_lp-1:0]] = data_i;
         idx_d = idx_q + len_width_lp'(1);
      end
   end

   // Lengths are powers of two, so word w repeats beat (w mod len)
   always_comb begin
      len_mask = idx_width_lp'(len_q - len_width_lp'(1));
      data_o   = '0;
      for (int unsigned w = 0; w < els_p; w++) begin
         data_o[w*width_p +: width_p] = mem_q[idx_width_lp'(w) & len_mask];
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         mem_q <= '0;
         idx_q <= '0;
         len_q <= '0;
      end else begin
         mem_q <= mem_d;
         idx_q <= idx_d;
         len_q <= len_d;
      end
   end

endmodule

// File: rtl/bp_me_burst_to_lite.sv
// Reassembles a BedRock burst message (header + N data beats) into one
// Lite message carrying the header and the full-width data.
// Ports: in_msg_header_* is the burst header channel, in_msg_data_* the
// beat channel, out_msg_* the Lite {header, data} output; all ready-valid-and.
// reset_i is asynchronous active-low; outputs stay low until one cycle after release.
module bp_me_burst_to_lite
   import bp_me_burst_to_lite_pkg::*;
#(
   parameter int unsigned in_data_width_p  = 64,
   parameter int unsigned out_data_width_p = 512,
   parameter logic [(1<<msg_type_width_gp)-1:0] payload_mask_p = '0,
   localparam int unsigned in_msg_header_width_lp = header_width_gp,
   localparam int unsigned out_msg_width_lp       = header_width_gp + out_data_width_p
) (
   input  logic                              clk_i,
   input  logic                              reset_i,
   input  logic [in_msg_header_width_lp-1:0] in_msg_header_i,
   input  logic                              in_msg_header_v_i,
   output logic                              in_msg_header_ready_and_o,
   input  logic [in_data_width_p-1:0]        in_msg_data_i,
   input  logic                              in_msg_data_v_i,
   output logic                              in_msg_data_ready_and_o,
   output logic [out_msg_width_lp-1:0]       out_msg_o,
   output logic                              out_msg_v_o,
   input  logic                              out_msg_ready_and_i
);

   localparam int unsigned burst_words_lp = out_data_width_p / in_data_width_p;
   localparam int unsigned count_width_lp = $clog2(burst_words_lp + 1);
   localparam int unsigned beat_bytes_lp  = in_data_width_p / 8;
   localparam int unsigned out_bytes_lp   = out_data_width_p / 8;

   typedef enum logic [1:0] {e_ready, e_data, e_send} state_e;

   state_e                      state_q, state_d;
   bedrock_header_s             header_q, header_d, in_header;
   logic                        has_data_q, has_data_d;
   logic                        init_q, init_d;
   logic                        header_ready_c, data_ready_c, out_v_c;
   logic                        sipo_load, sipo_v, sipo_last_c, sipo_full;
   logic                        in_oversize_c;
   logic [count_width_lp-1:0]   in_count;
   logic [out_data_width_p-1:0] sipo_data;

   assign in_header     = bedrock_header_s'(in_msg_header_i);
   assign in_count      = count_width_lp'(burst_beats(in_header.size, beat_bytes_lp, burst_words_lp));
   assign in_oversize_c = ((32'd1 << in_header.size) > out_bytes_lp);
   assign init_d        = 1'b1;

   bp_me_burst_sipo_dynamic #(
      .width_p (in_data_width_p),
      .els_p   (burst_words_lp)
   ) sipo (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .load_i   (sipo_load),
      .len_i    (in_count),
      .v_i      (sipo_v),
      .data_i   (in_msg_data_i),
      .last_c_o (sipo_last_c),
      .full_o   (sipo_full),
      .data_o   (sipo_data)
   );

   // Next-state and handshake decode; init_q keeps readies low straight out of reset
   always_comb begin
      state_d        = state_q;
      header_d       = header_q;
      has_data_d     = has_data_q;
      header_ready_c = 1'b0;
      data_ready_c   = 1'b0;
      out_v_c        = 1'b0;
      sipo_load      = 1'b0;
      sipo_v         = 1'b0;
      unique case (state_q)
         e_ready: begin
            header_ready_c = init_q;
            if (in_msg_header_v_i && init_q) begin
               header_d   = in_header;
               has_data_d = payload_mask_p[in_header.msg_type];
               sipo_load  = 1'b1;
               state_d    = has_data_d ? e_data : e_send;
            end
         end
         e_data: begin
            data_ready_c = !sipo_full;
            if (in_msg_data_v_i && !sipo_full) begin
               sipo_v = 1'b1;
               if (sipo_last_c) state_d = e_send;
            end
         end
         e_send: begin
            out_v_c = 1'b1;
            if (out_msg_ready_and_i) state_d = e_ready;
         end
         default: state_d = e_ready;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q    <= e_ready;
         header_q   <= '0;
         has_data_q <= 1'b0;
         init_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         header_q   <= header_d;
         has_data_q <= has_data_d;
         init_q     <= init_d;
      end
   end

   assign in_msg_header_ready_and_o = header_ready_c;
   assign in_msg_data_ready_and_o   = data_ready_c;
   assign out_msg_v_o               = out_v_c;
   assign out_msg_o                 = {header_q, (has_data_q ? sipo_data : '0)};

   // A size wider than the Lite word is clamped; flag it in simulation
   assert property (@(posedge clk_i) disable iff (!reset_i) sipo_load |-> !in_oversize_c);

endmodule

// File: tb/tb_bp_me_burst_to_lite.sv
// Directed bench for bp_me_burst_to_lite with a 64-bit beat / 512-bit Lite config.
module tb_bp_me_burst_to_lite;
   import bp_me_burst_to_lite_pkg::*;

   localparam int unsigned in_w  = 64;
   localparam int unsigned out_w = 512;
   localparam int unsigned mw    = header_width_gp + out_w;

   logic                       clk_i = 1'b0;
   logic                       reset_i = 1'b0;
   logic [header_width_gp-1:0] in_msg_header_i;
   logic                       in_msg_header_v_i;
   logic                       in_msg_header_ready_and_o;
   logic [in_w-1:0]            in_msg_data_i;
   logic                       in_msg_data_v_i;
   logic                       in_msg_data_ready_and_o;
   logic [mw-1:0]              out_msg_o;
   logic                       out_msg_v_o;
   logic                       out_msg_ready_and_i;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   bp_me_burst_to_lite #(
      .in_data_width_p  (in_w),
      .out_data_width_p (out_w),
      .payload_mask_p   (16'h002A)
   ) dut (
      .clk_i                     (clk_i),
      .reset_i                   (reset_i),
      .in_msg_header_i           (in_msg_header_i),
      .in_msg_header_v_i         (in_msg_header_v_i),
      .in_msg_header_ready_and_o (in_msg_header_ready_and_o),
      .in_msg_data_i             (in_msg_data_i),
      .in_msg_data_v_i           (in_msg_data_v_i),
      .in_msg_data_ready_and_o   (in_msg_data_ready_and_o),
      .out_msg_o                 (out_msg_o),
      .out_msg_v_o               (out_msg_v_o),
      .out_msg_ready_and_i       (out_msg_ready_and_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Offer a header from a negedge; return at the negedge after it is taken
   task automatic send_hdr(input bedrock_header_s h);
      bit took = 1'b0;
      in_msg_header_i   = h;
      in_msg_header_v_i = 1'b1;
      for (int i = 0; i < 20 && !took; i++) begin
         took = in_msg_header_ready_and_o;
         @(negedge clk_i);
      end
      in_msg_header_v_i = 1'b0;
      check("hdr_taken", 640'(took), 640'(1));
   endtask

   task automatic send_beat(input logic [in_w-1:0] d);
      bit took = 1'b0;
      in_msg_data_i   = d;
      in_msg_data_v_i = 1'b1;
      for (int i = 0; i < 20 && !took; i++) begin
         took = in_msg_data_ready_and_o;
         @(negedge clk_i);
      end
      in_msg_data_v_i = 1'b0;
      check("beat_taken", 640'(took), 640'(1));
   endtask

   task automatic recv(input string tag, input logic [mw-1:0] exp);
      bit seen = 1'b0;
      out_msg_ready_and_i = 1'b1;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (out_msg_v_o) begin
            seen = 1'b1;
            check(tag, 640'(out_msg_o), 640'(exp));
         end
         @(negedge clk_i);
      end
      out_msg_ready_and_i = 1'b0;
      check({tag, "_v"}, 640'(seen), 640'(1));
   endtask

   initial begin
      bedrock_header_s h1, h2, h3, h4, h5, h6, h7;
      logic [out_w-1:0] d5;

      in_msg_header_i     = '0;
      in_msg_header_v_i   = 1'b0;
      in_msg_data_i       = '0;
      in_msg_data_v_i     = 1'b0;
      out_msg_ready_and_i = 1'b0;

      h1 = '{payload: 16'h1111, size: e_bedrock_msg_size_64, addr: 40'h00_8000_0040, msg_type: e_bedrock_mem_wr};
      h2 = '{payload: 16'h2222, size: e_bedrock_msg_size_16, addr: 40'h00_8000_0100, msg_type: e_bedrock_mem_wr};
      h3 = '{payload: 16'h3333, size: e_bedrock_msg_size_1,  addr: 40'h00_0000_1003, msg_type: e_bedrock_mem_uc_wr};
      h4 = '{payload: 16'h4444, size: e_bedrock_msg_size_64, addr: 40'h00_8000_0200, msg_type: e_bedrock_mem_rd};
      h5 = '{payload: 16'h5555, size: e_bedrock_msg_size_16, addr: 40'h00_8000_0300, msg_type: e_bedrock_mem_amo};
      h6 = '{payload: 16'h6666, size: e_bedrock_msg_size_8,  addr: 40'h00_0000_2000, msg_type: e_bedrock_mem_uc_rd};
      h7 = '{payload: 16'h7777, size: e_bedrock_msg_size_64, addr: 40'h00_8000_0400, msg_type: e_bedrock_mem_wr};

      // Reset state and first-ready timing
      repeat (3) @(negedge clk_i);
      check("rst_hdr_rdy",  640'(in_msg_header_ready_and_o), 640'(0));
      check("rst_data_rdy", 640'(in_msg_data_ready_and_o),   640'(0));
      check("rst_out_v",    640'(out_msg_v_o),               640'(0));
      check("rst_msg",      640'(out_msg_o),                 640'(0));
      reset_i = 1'b1;
      check("rel_hdr_rdy",  640'(in_msg_header_ready_and_o), 640'(0));
      @(negedge clk_i);
      check("init_hdr_rdy", 640'(in_msg_header_ready_and_o), 640'(1));

      // 64B write, 8 beats in order
      send_hdr(h1);
      check("t1_data_rdy", 640'(in_msg_data_ready_and_o),   640'(1));
      check("t1_hdr_rdy",  640'(in_msg_header_ready_and_o), 640'(0));
      for (int k = 0; k < 8; k++) send_beat(64'(k));
      check("t1_out_v_lat", 640'(out_msg_v_o), 640'(1));
      recv("t1_msg", {h1, 64'h7, 64'h6, 64'h5, 64'h4, 64'h3, 64'h2, 64'h1, 64'h0});

      // 16B write, 2 beats replicated 4x
      send_hdr(h2);
      send_beat(64'hA);
      check("t2_data_rdy_mid", 640'(in_msg_data_ready_and_o), 640'(1));
      send_beat(64'hB);
      check("t2_data_rdy_end", 640'(in_msg_data_ready_and_o), 640'(0));
      check("t2_out_v", 640'(out_msg_v_o), 640'(1));
      recv("t2_msg", {h2, {4{64'hB, 64'hA}}});

      // 1B write, single beat replicated 8x
      send_hdr(h3);
      send_beat(64'h0123_4567_89AB_CDEF);
      check("t3_data_rdy", 640'(in_msg_data_ready_and_o), 640'(0));
      recv("t3_msg", {h3, {8{64'h0123_4567_89AB_CDEF}}});

      // Header-only read with a beat offered alongside
      in_msg_data_i   = 64'hDEAD_BEEF_DEAD_BEEF;
      in_msg_data_v_i = 1'b1;
      check("t4_data_rdy_pre", 640'(in_msg_data_ready_and_o), 640'(0));
      send_hdr(h4);
      check("t4_out_v_lat",     640'(out_msg_v_o),             640'(1));
      check("t4_data_rdy_send", 640'(in_msg_data_ready_and_o), 640'(0));
      recv("t4_msg", {h4, 512'h0});
      check("t4_data_rdy_post", 640'(in_msg_data_ready_and_o), 640'(0));
      in_msg_data_v_i = 1'b0;

      // Backpressure for 10 cycles, then back-to-back header
      send_hdr(h5);
      send_beat(64'h1);
      send_beat(64'h2);
      d5 = {4{64'h2, 64'h1}};
      for (int c = 0; c < 10; c++) begin
         check("t5_hold_msg", 640'(out_msg_o),                 640'({h5, d5}));
         check("t5_hold_hdr", 640'(in_msg_header_ready_and_o), 640'(0));
         @(negedge clk_i);
      end
      in_msg_header_i     = h6;
      in_msg_header_v_i   = 1'b1;
      out_msg_ready_and_i = 1'b1;
      @(negedge clk_i);
      out_msg_ready_and_i = 1'b0;
      check("t5_hdr_rdy_after", 640'(in_msg_header_ready_and_o), 640'(1));
      check("t5_out_v_after",   640'(out_msg_v_o),               640'(0));
      send_hdr(h6);
      check("t6_out_v_lat", 640'(out_msg_v_o), 640'(1));
      recv("t6_msg", {h6, 512'h0});

      // Reset mid-message drops partial beats
      send_hdr(h7);
      for (int k = 0; k < 3; k++) send_beat(64'hDEAD_0000 + 64'(k));
      #2 reset_i = 1'b0;
      #1;
      check("t7_rst_hdr_rdy",  640'(in_msg_header_ready_and_o), 640'(0));
      check("t7_rst_data_rdy", 640'(in_msg_data_ready_and_o),   640'(0));
      check("t7_rst_out_v",    640'(out_msg_v_o),               640'(0));
      @(negedge clk_i);
      reset_i = 1'b1;
      @(negedge clk_i);
      send_hdr(h7);
      for (int k = 0; k < 8; k++) send_beat(64'h10 + 64'(k));
      recv("t7_msg", {h7, 64'h17, 64'h16, 64'h15, 64'h14, 64'h13, 64'h12, 64'h11, 64'h10});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
